// File: rtl/uart_rx_word.sv
// UART receive front end: synchronizes rx_pin, deserializes one start/DATA_BITS/stop
// frame LSB first and presents the word in a valid/ready holding register.
module uart_rx_word #(
    parameter int unsigned CLK_FRE   = 50,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    input  logic                 rx_en,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int unsigned CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    wire cnt_half_w = (cnt_q == CNT_W'(HALF - 1));
    wire cnt_full_w = (cnt_q == CNT_W'(CYCLE - 1));

    // Two-flop synchronizer; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // A consumer pop; a word completing this cycle overrides it below.
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rx_en && !rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_half_w) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_full_w) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_full_w) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!valid_q || rx_ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit (50 MHz / 3.125 Mbaud).
module tb_uart_rx_word;

    localparam int unsigned CYC  = 16;
    localparam int unsigned HLF  = CYC / 2;
    localparam int          FRM  = 34 * CYC;
    // Loop index whose following posedge is the stop-bit sample (2 sync + 1 detect).
    localparam int          DONE_AT = 2 + HLF + 33 * CYC;

    logic        clk;
    logic        rst;
    logic        rx_pin;
    logic        rx_en;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    int total;
    int bad;
    int fe_cnt;
    int ov_cnt;
    int busy_cnt;
    int fe0, ov0, busy0;

    uart_rx_word #(
        .CLK_FRE  (50),
        .BAUD_RATE(3125000),
        .DATA_BITS(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .rx_en    (rx_en),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        fe_cnt   <= fe_cnt + int'(frame_err);
        ov_cnt   <= ov_cnt + int'(overrun);
        busy_cnt <= busy_cnt + int'(rx_busy);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic snap();
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        busy0 = busy_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, one clock per iteration; optional hooks pulse rx_ready,
    // drop rx_en, or pulse rst (which abandons the rest of the frame).
    task automatic send_frame(input logic [31:0] w, input logic stop_b,
                              input int ready_at, input int en_off_at, input int rst_at);
        logic [33:0] fr;
        fr = {stop_b, w, 1'b0};
        for (int i = 0; i < FRM; i++) begin
            rx_pin = fr[i / CYC];
            if (i == ready_at) rx_ready = 1'b1;
            else if (ready_at >= 0 && i == ready_at + 1) rx_ready = 1'b0;
            if (i == en_off_at) rx_en = 1'b0;
            if (i == rst_at) rst = 1'b1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst    = 1'b0;
                rx_pin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        fe_cnt = 0; ov_cnt = 0; busy_cnt = 0;
        rst = 1'b1; rx_pin = 1'b1; rx_en = 1'b0; rx_ready = 1'b0;
        idle(3);
        check("rst_data",  rx_data, 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy",  32'(rx_busy), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun), 32'h0);
        rst = 1'b0;
        rx_en = 1'b1;
        idle(4);

        // Basic frame, word held until consumed
        send_frame(32'hF6CCAAE7, 1'b1, -1, -1, -1);
        idle(4);
        check("t1_data",  rx_data, 32'hF6CCAAE7);
        check("t1_valid", 32'(rx_valid), 32'h1);
        idle(20);
        check("t1_hold",  32'(rx_valid), 32'h1);
        pop();
        check("t1_pop",      32'(rx_valid), 32'h0);
        check("t1_data_kept", rx_data, 32'hF6CCAAE7);

        // Short low glitch is rejected at mid start bit
        idle(4);
        snap();
        rx_pin = 1'b0;
        idle(3);
        rx_pin = 1'b1;
        idle(20);
        check("t2_busy_cycles", 32'(busy_cnt - busy0), 32'(HLF));
        check("t2_busy", 32'(rx_busy), 32'h0);
        check("t2_valid", 32'(rx_valid), 32'h0);
        check("t2_ferr", 32'(fe_cnt - fe0), 32'h0);

        // Bad stop bit
        snap();
        send_frame(32'h12345678, 1'b0, -1, -1, -1);
        rx_pin = 1'b1;
        idle(CYC);
        check("t3_ferr_cycles", 32'(fe_cnt - fe0), 32'h1);
        check("t3_valid", 32'(rx_valid), 32'h0);
        check("t3_ovr", 32'(ov_cnt - ov0), 32'h0);

        // Back-to-back with no consumer: second word dropped
        snap();
        send_frame(32'hA5A5A5A5, 1'b1, -1, -1, -1);
        send_frame(32'h5A5A5A5A, 1'b1, -1, -1, -1);
        idle(4);
        check("t4a_data", rx_data, 32'hA5A5A5A5);
        check("t4a_valid", 32'(rx_valid), 32'h1);
        check("t4a_ovr", 32'(ov_cnt - ov0), 32'h1);
        pop();

        // Back-to-back with rx_ready at second completion: word replaced
        snap();
        send_frame(32'hA5A5A5A5, 1'b1, -1, -1, -1);
        send_frame(32'h5A5A5A5A, 1'b1, DONE_AT, -1, -1);
        idle(4);
        check("t4b_data", rx_data, 32'h5A5A5A5A);
        check("t4b_valid", 32'(rx_valid), 32'h1);
        check("t4b_ovr", 32'(ov_cnt - ov0), 32'h0);
        pop();

        // rx_en low blocks start detection entirely
        idle(4);
        rx_en = 1'b0;
        snap();
        send_frame(32'hFFFF0000, 1'b1, -1, -1, -1);
        idle(4);
        check("t5_busy_cycles", 32'(busy_cnt - busy0), 32'h0);
        check("t5_valid", 32'(rx_valid), 32'h0);

        // rx_en dropped mid-frame does not abort it
        rx_en = 1'b1;
        send_frame(32'h13579BDF, 1'b1, -1, 100, -1);
        idle(4);
        check("t5_en_off_data", rx_data, 32'h13579BDF);
        check("t5_en_off_valid", 32'(rx_valid), 32'h1);
        rx_en = 1'b1;

        // Reset mid data bit 10 clears everything, next frame is clean
        snap();
        send_frame(32'hCAFEF00D, 1'b1, -1, -1, 11 * CYC + 5);
        check("t6_rst_data",  rx_data, 32'h0);
        check("t6_rst_valid", 32'(rx_valid), 32'h0);
        check("t6_rst_busy",  32'(rx_busy), 32'h0);
        idle(2 * CYC);
        check("t6_idle_busy", 32'(rx_busy), 32'h0);
        send_frame(32'hDEADBEEF, 1'b1, -1, -1, -1);
        idle(4);
        check("t6_data",  rx_data, 32'hDEADBEEF);
        check("t6_valid", 32'(rx_valid), 32'h1);
        check("t6_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
